// File: rtl/id_pool_mfma.sv
// Multi-port ID free-list: N_ALLOC combinational offers, N_FREE compacted returns.
// Optional in-pool bitmap drops and reports double or out-of-range frees.
module id_pool_mfma #(
  parameter  int DEPTH     = 16,
  parameter  int N_FREE    = 2,
  parameter  int N_ALLOC   = 2,
  parameter  int CHECK_DUP = 1,
  parameter  int LOW_WM    = 2,
  localparam int ID_W      = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_FREE-1:0]                c_srdy,
  output logic [N_FREE-1:0]                c_drdy,
  input  logic [N_FREE-1:0][ID_W-1:0]      c_data,
  output logic [N_ALLOC-1:0]               p_srdy,
  input  logic [N_ALLOC-1:0]               p_drdy,
  output logic [N_ALLOC-1:0][ID_W-1:0]     p_data,
  output logic [CNT_W-1:0]                 usage,
  output logic                             low_wm,
  output logic                             err_dup,
  output logic [ID_W-1:0]                  err_dup_id
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ID_W:0]    DEPTH_X = (ID_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LOW_C   = CNT_W'(LOW_WM);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [ID_W-1:0]  mem_d [DEPTH];
  logic [ID_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ID_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] usage_q, usage_d;
  logic [DEPTH-1:0] bmap_q, bmap_d;
  logic             low_q;
  logic             err_q, err_d;
  logic [ID_W-1:0]  err_id_q, err_id_d;

  logic [CNT_W-1:0]  pops;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  credit;
  logic [CNT_W-1:0]  pref;
  logic [N_FREE-1:0] acc;
  logic              run;
  logic              legal;
  logic [CNT_W:0]    usage_sum;

  // Pointer add modulo DEPTH; off <= DEPTH so one subtraction suffices.
  function automatic logic [ID_W-1:0] wrap(
    input logic [ID_W-1:0]  base,
    input logic [CNT_W-1:0] off
  );
    logic [CNT_W:0] sum;
    sum = (CNT_W+1)'(base) + (CNT_W+1)'(off);
    if (sum >= (CNT_W+1)'(DEPTH)) begin
      sum = sum - (CNT_W+1)'(DEPTH);
    end
    return sum[ID_W-1:0];
  endfunction

  always_comb begin
    for (int j = 0; j < N_ALLOC; j++) begin
      p_srdy[j] = (usage_q > CNT_W'(j));
      p_data[j] = mem_q[wrap(rd_ptr_q, CNT_W'(j))];
    end
  end

  always_comb begin
    pops = '0;
    run  = 1'b1;
    for (int j = 0; j < N_ALLOC; j++) begin
      if (run && p_srdy[j] && p_drdy[j]) begin
        pops = pops + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Credit comes from registered usage only.
  always_comb begin
    credit = DEPTH_C - usage_q;
    pref   = '0;
    for (int i = 0; i < N_FREE; i++) begin
      pref      = pref + CNT_W'(c_srdy[i]);
      c_drdy[i] = (pref <= credit);
    end
  end

  always_comb begin
    mem_d    = mem_q;
    bmap_d   = bmap_q;
    wr_cnt   = '0;
    err_d    = 1'b0;
    err_id_d = err_id_q;
    acc      = c_srdy & c_drdy;
    legal    = 1'b0;
    for (int j = 0; j < N_ALLOC; j++) begin
      if (CNT_W'(j) < pops) begin
        bmap_d[p_data[j]] = 1'b0;
      end
    end
    for (int i = 0; i < N_FREE; i++) begin
      legal = acc[i];
      if (CHECK_DUP != 0 && acc[i]) begin
        if ({1'b0, c_data[i]} >= DEPTH_X) begin
          legal = 1'b0;
        end else if (bmap_q[c_data[i]]) begin
          legal = 1'b0;
        end
        for (int k = 0; k < i; k++) begin
          if (acc[k] && c_data[k] == c_data[i]) begin
            legal = 1'b0;
          end
        end
        if (!legal && !err_d) begin
          err_d    = 1'b1;
          err_id_d = c_data[i];
        end
      end
      if (legal) begin
        mem_d[wrap(wr_ptr_q, wr_cnt)] = c_data[i];
        bmap_d[c_data[i]]             = 1'b1;
        wr_cnt                        = wr_cnt + CNT_W'(1);
      end
    end
    rd_ptr_d  = wrap(rd_ptr_q, pops);
    wr_ptr_d  = wrap(wr_ptr_q, wr_cnt);
    usage_sum = {1'b0, usage_q} + {1'b0, wr_cnt};
    usage_d   = usage_q + wr_cnt - pops;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ID_W'(i);
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= DEPTH_C;
      bmap_q   <= '1;
      low_q    <= (DEPTH <= LOW_WM);
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      assert (usage_sum >= {1'b0, pops});
      assert (usage_sum - {1'b0, pops} <= {1'b0, DEPTH_C});
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      usage_q  <= usage_d;
      bmap_q   <= bmap_d;
      low_q    <= (usage_d <= LOW_C);
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  assign usage      = usage_q;
  assign low_wm     = low_q;
  assign err_dup    = err_q;
  assign err_dup_id = err_id_q;

endmodule

// File: tb/tb_id_pool_mfma.sv
// Directed bench for id_pool_mfma (DEPTH=16, 2 free / 2 alloc ports).
// Each scenario task carries its own hand-computed expectations.
module tb_id_pool_mfma;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      c_srdy = '0;
  logic [1:0]      c_drdy;
  logic [1:0][3:0] c_data = '0;
  logic [1:0]      p_srdy;
  logic [1:0]      p_drdy = '0;
  logic [1:0][3:0] p_data;
  logic [4:0]      usage;
  logic            low_wm;
  logic            err_dup;
  logic [3:0]      err_dup_id;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_pool_mfma dut (
    .clk        (clk),
    .rst        (rst),
    .c_srdy     (c_srdy),
    .c_drdy     (c_drdy),
    .c_data     (c_data),
    .p_srdy     (p_srdy),
    .p_drdy     (p_drdy),
    .p_data     (p_data),
    .usage      (usage),
    .low_wm     (low_wm),
    .err_dup    (err_dup),
    .err_dup_id (err_dup_id)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    c_srdy = 2'b11;
    #1;
    checks++;
    if (usage !== 5'd16) begin
      failures++;
      $display("FAIL reset_usage got=%0d exp=16", usage);
    end
    checks++;
    if (p_data[0] !== 4'd0 || p_data[1] !== 4'd1) begin
      failures++;
      $display("FAIL reset_pdata got=%0d,%0d exp=0,1", p_data[0], p_data[1]);
    end
    checks++;
    if (p_srdy !== 2'b11) begin
      failures++;
      $display("FAIL reset_psrdy got=%b exp=11", p_srdy);
    end
    checks++;
    if (low_wm !== 1'b0 || err_dup !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b exp=00", low_wm, err_dup);
    end
    checks++;
    if (c_drdy !== 2'b00) begin
      failures++;
      $display("FAIL reset_cdrdy_full got=%b exp=00", c_drdy);
    end
    c_srdy = 2'b00;
  endtask

  task automatic test_drain;
    int u;
    for (int c = 0; c < 8; c++) begin
      p_drdy = 2'b11;
      #1;
      checks++;
      if (p_data[0] !== 4'(2*c) || p_data[1] !== 4'(2*c+1) || p_srdy !== 2'b11) begin
        failures++;
        $display("FAIL drain_offer c=%0d got=%0d,%0d srdy=%b exp=%0d,%0d srdy=11",
                 c, p_data[0], p_data[1], p_srdy, 2*c, 2*c+1);
      end
      tick();
      u = 16 - 2*(c+1);
      checks++;
      if (usage !== 5'(u) || low_wm !== (u <= 2)) begin
        failures++;
        $display("FAIL drain_usage c=%0d got=%0d lw=%b exp=%0d lw=%b",
                 c, usage, low_wm, u, (u <= 2));
      end
    end
    p_drdy = 2'b00;
  endtask

  task automatic test_empty_free;
    p_drdy = 2'b11;
    c_srdy = 2'b10;
    c_data[0] = 4'd9;
    c_data[1] = 4'd5;
    #1;
    checks++;
    if (p_srdy !== 2'b00) begin
      failures++;
      $display("FAIL empty_psrdy got=%b exp=00", p_srdy);
    end
    checks++;
    if ((c_srdy & c_drdy) !== 2'b10) begin
      failures++;
      $display("FAIL empty_accept got=%b exp=10", c_srdy & c_drdy);
    end
    tick();
    p_drdy = 2'b00;
    c_srdy = 2'b00;
    #1;
    checks++;
    if (usage !== 5'd1 || p_data[0] !== 4'd5 || p_srdy !== 2'b01) begin
      failures++;
      $display("FAIL empty_refill got u=%0d d=%0d s=%b exp u=1 d=5 s=01",
               usage, p_data[0], p_srdy);
    end
    checks++;
    if (low_wm !== 1'b1 || err_dup !== 1'b0) begin
      failures++;
      $display("FAIL empty_flags got=%b%b exp=10", low_wm, err_dup);
    end
  endtask

  task automatic test_refill;
    int pa[7] = '{0, 2, 4, 7, 9, 11, 13};
    int pb[7] = '{1, 3, 6, 8, 10, 12, 14};
    for (int i = 0; i < 7; i++) begin
      c_srdy = 2'b11;
      c_data[0] = 4'(pa[i]);
      c_data[1] = 4'(pb[i]);
      tick();
    end
    c_srdy = 2'b00;
    checks++;
    if (usage !== 5'd15 || err_dup !== 1'b0) begin
      failures++;
      $display("FAIL refill got u=%0d e=%b exp u=15 e=0", usage, err_dup);
    end
  endtask

  task automatic test_full_credit;
    c_srdy = 2'b11;
    c_data[0] = 4'd15;
    c_data[1] = 4'd5;
    p_drdy = 2'b01;
    #1;
    checks++;
    if (c_drdy !== 2'b01 || p_data[0] !== 4'd5) begin
      failures++;
      $display("FAIL credit15 got drdy=%b d=%0d exp drdy=01 d=5", c_drdy, p_data[0]);
    end
    tick();
    c_srdy = 2'b00;
    p_drdy = 2'b00;
    checks++;
    if (usage !== 5'd15 || err_dup !== 1'b0) begin
      failures++;
      $display("FAIL credit15_usage got u=%0d e=%b exp u=15 e=0", usage, err_dup);
    end
    c_srdy = 2'b11;
    c_data[0] = 4'd5;
    c_data[1] = 4'd0;
    #1;
    checks++;
    if (c_drdy !== 2'b01) begin
      failures++;
      $display("FAIL credit_fill got drdy=%b exp=01", c_drdy);
    end
    tick();
    checks++;
    if (usage !== 5'd16 || low_wm !== 1'b0) begin
      failures++;
      $display("FAIL credit_fill_usage got u=%0d lw=%b exp u=16 lw=0", usage, low_wm);
    end
    c_data[0] = 4'd0;
    c_data[1] = 4'd1;
    p_drdy = 2'b11;
    #1;
    checks++;
    if (c_drdy !== 2'b00 || p_data[0] !== 4'd0 || p_data[1] !== 4'd1) begin
      failures++;
      $display("FAIL full_pop got drdy=%b d=%0d,%0d exp drdy=00 d=0,1",
               c_drdy, p_data[0], p_data[1]);
    end
    tick();
    c_srdy = 2'b00;
    p_drdy = 2'b00;
    checks++;
    if (usage !== 5'd14 || err_dup !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_usage got u=%0d e=%b exp u=14 e=0", usage, err_dup);
    end
  endtask

  task automatic test_dup;
    c_srdy = 2'b01;
    c_data[0] = 4'd3;
    #1;
    checks++;
    if (c_drdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL dup_drdy got=%b exp=1", c_drdy[0]);
    end
    tick();
    c_srdy = 2'b00;
    checks++;
    if (err_dup !== 1'b1 || err_dup_id !== 4'd3 || usage !== 5'd14) begin
      failures++;
      $display("FAIL dup_inpool got e=%b id=%0d u=%0d exp e=1 id=3 u=14",
               err_dup, err_dup_id, usage);
    end
    tick();
    checks++;
    if (err_dup !== 1'b0 || err_dup_id !== 4'd3) begin
      failures++;
      $display("FAIL dup_pulse got e=%b id=%0d exp e=0 id=3", err_dup, err_dup_id);
    end
    c_srdy = 2'b11;
    c_data[0] = 4'd1;
    c_data[1] = 4'd1;
    tick();
    c_srdy = 2'b00;
    checks++;
    if (usage !== 5'd15 || err_dup !== 1'b1 || err_dup_id !== 4'd1) begin
      failures++;
      $display("FAIL dup_sameport got u=%0d e=%b id=%0d exp u=15 e=1 id=1",
               usage, err_dup, err_dup_id);
    end
    p_drdy = 2'b01;
    c_srdy = 2'b01;
    c_data[0] = 4'd2;
    #1;
    checks++;
    if (p_data[0] !== 4'd2) begin
      failures++;
      $display("FAIL dup_popfree_offer got=%0d exp=2", p_data[0]);
    end
    tick();
    p_drdy = 2'b00;
    c_srdy = 2'b00;
    checks++;
    if (usage !== 5'd14 || err_dup !== 1'b1 || err_dup_id !== 4'd2) begin
      failures++;
      $display("FAIL dup_popfree got u=%0d e=%b id=%0d exp u=14 e=1 id=2",
               usage, err_dup, err_dup_id);
    end
    c_srdy = 2'b11;
    c_data[0] = 4'd4;
    c_data[1] = 4'd6;
    tick();
    c_srdy = 2'b00;
    checks++;
    if (usage !== 5'd14 || err_dup !== 1'b1 || err_dup_id !== 4'd4) begin
      failures++;
      $display("FAIL dup_lowest got u=%0d e=%b id=%0d exp u=14 e=1 id=4",
               usage, err_dup, err_dup_id);
    end
  endtask

  task automatic test_gap;
    p_drdy = 2'b10;
    #1;
    checks++;
    if (p_data[0] !== 4'd3 || p_srdy !== 2'b11) begin
      failures++;
      $display("FAIL gap_offer got d=%0d s=%b exp d=3 s=11", p_data[0], p_srdy);
    end
    tick();
    p_drdy = 2'b00;
    checks++;
    if (usage !== 5'd14 || p_data[0] !== 4'd3 || err_dup !== 1'b0) begin
      failures++;
      $display("FAIL gap_nopop got u=%0d d=%0d e=%b exp u=14 d=3 e=0",
               usage, p_data[0], err_dup);
    end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    p_drdy = 2'b11;
    c_srdy = 2'b11;
    c_data[0] = 4'd0;
    c_data[1] = 4'd2;
    tick();
    rst = 1'b0;
    p_drdy = 2'b00;
    c_srdy = 2'b00;
    #1;
    checks++;
    if (usage !== 5'd16 || p_data[0] !== 4'd0 || p_data[1] !== 4'd1 || p_srdy !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid got u=%0d d=%0d,%0d s=%b exp u=16 d=0,1 s=11",
               usage, p_data[0], p_data[1], p_srdy);
    end
    checks++;
    if (err_dup !== 1'b0 || err_dup_id !== 4'd0 || low_wm !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_flags got e=%b id=%0d lw=%b exp e=0 id=0 lw=0",
               err_dup, err_dup_id, low_wm);
    end
  endtask

  task automatic test_back_to_back;
    p_drdy = 2'b01;
    tick();
    for (int k = 0; k < 4; k++) begin
      p_drdy = 2'b01;
      c_srdy = 2'b01;
      c_data[0] = 4'(k);
      #1;
      checks++;
      if (p_data[0] !== 4'(k+1) || c_drdy[0] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_offer k=%0d got d=%0d r=%b exp d=%0d r=1",
                 k, p_data[0], c_drdy[0], k+1);
      end
      tick();
      checks++;
      if (usage !== 5'd15 || err_dup !== 1'b0) begin
        failures++;
        $display("FAIL b2b_usage k=%0d got u=%0d e=%b exp u=15 e=0", k, usage, err_dup);
      end
    end
    p_drdy = 2'b00;
    c_srdy = 2'b00;
  endtask

  initial begin
    test_reset();
    test_drain();
    test_empty_free();
    test_refill();
    test_full_credit();
    test_dup();
    test_gap();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
